hex_scan_display: RTL

HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

---
 rtl/hex_scan_display.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hex_scan_display.sv
// Four-digit multiplexed hex display driver: prescaled digit scan, frame-synchronous
// double-buffered digit update, leading-zero blanking and per-digit blinking.
module hex_scan_display #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLINK = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic       load,
  input  logic       lz_blank,
  input  logic [3:0] blink_mask,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame,
  output logic       pending
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW = (BLINK > 1) ? $clog2(BLINK) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   stage_q, stage_d;
  logic [15:0]   disp_q, disp_d;
  logic          pending_q, pending_d;
  logic          phase_q, phase_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          frame_q, frame_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic          tick_c;
  logic          boundary_c;
  logic [3:0]    digit_c;
  logic [3:0]    lz_c;
  logic          blank_c;
  logic [6:0]    dec_c;

  // Scan timing, staging/display transfer and blink phase
  always_comb begin
    tick_c     = (presc_q == PW'(DIV - 1));
    boundary_c = tick_c && (sel_q == 2'd3);
    presc_d    = tick_c ? '0 : presc_q + PW'(1);
    sel_d      = tick_c ? sel_q + 2'd1 : sel_q;
    stage_d    = stage_q;
    disp_d     = disp_q;
    pending_d  = pending_q;
    phase_d    = phase_q;
    bcnt_d     = bcnt_q;
    frame_d    = boundary_c;
    // Transfer before capture so a coincident load stays pending for the next frame
    if (boundary_c && pending_q) begin
      disp_d    = stage_q;
      pending_d = 1'b0;
    end
    if (load) begin
      stage_d   = {d3, d2, d1, d0};
      pending_d = 1'b1;
    end
    if (boundary_c) begin
      if (bcnt_q == BW'(BLINK - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  // Segment/anode value for the currently selected digit
  always_comb begin
    case (sel_q)
      2'd0:    digit_c = disp_q[3:0];
      2'd1:    digit_c = disp_q[7:4];
      2'd2:    digit_c = disp_q[11:8];
      default: digit_c = disp_q[15:12];
    endcase
    lz_c[3] = (disp_q[15:12] == 4'h0);
    lz_c[2] = lz_c[3] && (disp_q[11:8] == 4'h0);
    lz_c[1] = lz_c[2] && (disp_q[7:4] == 4'h0);
    lz_c[0] = 1'b0;
    blank_c = (lz_blank && lz_c[sel_q]) || (phase_q && blink_mask[sel_q]);
    case (digit_c)
      4'h0:    dec_c = 7'h40;
      4'h1:    dec_c = 7'h79;
      4'h2:    dec_c = 7'h24;
      4'h3:    dec_c = 7'h30;
      4'h4:    dec_c = 7'h19;
      4'h5:    dec_c = 7'h12;
      4'h6:    dec_c = 7'h02;
      4'h7:    dec_c = 7'h78;
      4'h8:    dec_c = 7'h00;
      4'h9:    dec_c = 7'h10;
      4'hA:    dec_c = 7'h08;
      4'hB:    dec_c = 7'h03;
      4'hC:    dec_c = 7'h46;
      4'hD:    dec_c = 7'h21;
      4'hE:    dec_c = 7'h06;
      default: dec_c = 7'h0E;
    endcase
    an_d  = blank_c ? 4'hF : ~(4'b0001 << sel_q);
    seg_d = blank_c ? 7'h7F : dec_c;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q   <= '0;
      sel_q     <= 2'd0;
      stage_q   <= 16'h0000;
      disp_q    <= 16'h0000;
      pending_q <= 1'b0;
      phase_q   <= 1'b0;
      bcnt_q    <= '0;
      frame_q   <= 1'b0;
      seg_q     <= 7'h7F;
      an_q      <= 4'hF;
    end else begin
      presc_q   <= presc_d;
      sel_q     <= sel_d;
      stage_q   <= stage_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      phase_q   <= phase_d;
      bcnt_q    <= bcnt_d;
      frame_q   <= frame_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign frame   = frame_q;
  assign pending = pending_q;

endmodule
